// File: rtl/horner_sequencer.sv
// rtl/horner_sequencer.sv - Horner-rule polynomial sequencer driving a shared FP multiply-add unit
module horner_sequencer #(
  parameter int DEGREE  = 10,
  parameter int TIMEOUT = 255,
  parameter int CW      = 8
) (
  input  logic        clk,
  input  logic        GlobalReset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] z,
  input  logic [31:0] coeff0,
  input  logic [31:0] coeff1,
  input  logic [31:0] coeff2,
  input  logic [31:0] coeff3,
  input  logic [31:0] coeff4,
  input  logic [31:0] coeff5,
  input  logic [31:0] coeff6,
  input  logic [31:0] coeff7,
  input  logic [31:0] coeff8,
  input  logic [31:0] coeff9,
  input  logic [31:0] coeff10,
  output logic        mac_req,
  output logic [31:0] mac_a,
  output logic [31:0] mac_b,
  output logic [31:0] mac_c,
  input  logic        mac_ack,
  input  logic [31:0] mac_result,
  output logic        y_valid,
  input  logic        y_ready,
  output logic [31:0] y,
  output logic        err
);

  localparam logic [1:0]    S_IDLE  = 2'd0;
  localparam logic [1:0]    S_BUSY  = 2'd1;
  localparam logic [1:0]    S_DONE  = 2'd2;
  localparam logic [3:0]    K_START = 4'(DEGREE - 1);
  localparam logic [CW-1:0] T_LAST  = CW'(TIMEOUT - 1);
  localparam logic [31:0]   QNAN    = 32'h7FC0_0000;

  logic [1:0]    state;
  logic [3:0]    k;
  logic [3:0]    k_dec;
  logic [CW-1:0] tcnt;
  logic [31:0]   acc;
  logic [31:0]   z_r;
  logic [31:0]   c_r  [0:10];
  logic [31:0]   c_in [0:10];

  assign c_in[0]  = coeff0;
  assign c_in[1]  = coeff1;
  assign c_in[2]  = coeff2;
  assign c_in[3]  = coeff3;
  assign c_in[4]  = coeff4;
  assign c_in[5]  = coeff5;
  assign c_in[6]  = coeff6;
  assign c_in[7]  = coeff7;
  assign c_in[8]  = coeff8;
  assign c_in[9]  = coeff9;
  assign c_in[10] = coeff10;

  assign k_dec    = k - 4'd1;
  assign in_ready = (state == S_IDLE);
  assign y_valid  = (state == S_DONE);

  // The accumulator and z snapshot double as the registered multiplicand/multiplier.
  assign mac_a = acc;
  assign mac_b = z_r;

  always_ff @(posedge clk or negedge GlobalReset) begin
    if (!GlobalReset) begin
      state   <= S_IDLE;
      k       <= 4'd0;
      tcnt    <= '0;
      acc     <= 32'h0;
      z_r     <= 32'h0;
      mac_c   <= 32'h0;
      mac_req <= 1'b0;
      y       <= 32'h0;
      err     <= 1'b0;
      for (int i = 0; i <= 10; i++) c_r[i] <= 32'h0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            z_r <= z;
            for (int i = 0; i <= 10; i++) c_r[i] <= c_in[i];
            acc     <= c_in[DEGREE];
            mac_c   <= c_in[DEGREE-1];
            k       <= K_START;
            tcnt    <= '0;
            err     <= 1'b0;
            mac_req <= 1'b1;
            state   <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (mac_ack) begin
            acc  <= mac_result;
            tcnt <= '0;
            if (k == 4'd0) begin
              y       <= mac_result;
              mac_req <= 1'b0;
              state   <= S_DONE;
            end else begin
              // Next operands land one cycle after the ack; mac_req stays high.
              k     <= k_dec;
              mac_c <= c_r[k_dec];
            end
          end else if (tcnt == T_LAST) begin
            y       <= QNAN;
            err     <= 1'b1;
            mac_req <= 1'b0;
            state   <= S_DONE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        S_DONE: begin
          if (y_ready) state <= S_IDLE;
        end
        default: begin
          state   <= S_IDLE;
          mac_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_horner_sequencer.sv
// tb/tb_horner_sequencer.sv - directed scoreboard bench for horner_sequencer with a behavioural FP multiply-add
module tb_horner_sequencer;

  localparam int DEGREE  = 10;
  localparam int TIMEOUT = 16;
  localparam int CW      = 8;

  logic        clk = 1'b0;
  logic        GlobalReset = 1'b0;
  logic        in_valid = 1'b0;
  logic        y_ready = 1'b0;
  logic        mac_ack = 1'b0;
  logic [31:0] mac_result = 32'h0;
  logic [31:0] z = 32'h0;
  logic [31:0] coeff [0:10];
  logic        in_ready, mac_req, y_valid, err;
  logic [31:0] mac_a, mac_b, mac_c, y;

  int errors = 0;
  int checks = 0;

  logic [31:0] sb_y [$];
  logic        sb_e [$];

  int          ack_wait = 0;
  int          op_age = 0;
  int          n_ops = 0;
  int          req_cycles = 0;
  bit          inject_ack = 1'b0;
  logic [31:0] op_a, op_b, op_c;
  logic [31:0] a_log [$];

  horner_sequencer #(.DEGREE(DEGREE), .TIMEOUT(TIMEOUT), .CW(CW)) dut (
    .clk(clk), .GlobalReset(GlobalReset),
    .in_valid(in_valid), .in_ready(in_ready), .z(z),
    .coeff0(coeff[0]), .coeff1(coeff[1]), .coeff2(coeff[2]), .coeff3(coeff[3]),
    .coeff4(coeff[4]), .coeff5(coeff[5]), .coeff6(coeff[6]), .coeff7(coeff[7]),
    .coeff8(coeff[8]), .coeff9(coeff[9]), .coeff10(coeff[10]),
    .mac_req(mac_req), .mac_a(mac_a), .mac_b(mac_b), .mac_c(mac_c),
    .mac_ack(mac_ack), .mac_result(mac_result),
    .y_valid(y_valid), .y_ready(y_ready), .y(y), .err(err)
  );

  always #5 clk = ~clk;

  function automatic real f2r(logic [31:0] f);
    logic [10:0] e;
    if (f[30:0] == 31'h0) return 0.0;
    e = 11'(int'(f[30:23]) - 127 + 1023);
    return $bitstoreal({f[31], e, f[22:0], 29'h0});
  endfunction

  function automatic logic [31:0] r2f(real r);
    logic [63:0] d;
    int          e;
    if (r == 0.0) return 32'h0;
    d = $realtobits(r);
    e = int'(d[62:52]) - 1023 + 127;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Behavioural multiply-add: acks after ack_wait extra cycles, checks operand stability.
  always @(negedge clk) begin
    if (inject_ack) begin
      mac_ack    = 1'b1;
      mac_result = 32'hDEAD_BEEF;
      inject_ack = 1'b0;
    end else if (GlobalReset && mac_req) begin
      req_cycles++;
      if (op_age == 0) begin
        op_a = mac_a;
        op_b = mac_b;
        op_c = mac_c;
      end else begin
        check("op_a_stable", mac_a, op_a);
        check("op_b_stable", mac_b, op_b);
        check("op_c_stable", mac_c, op_c);
      end
      if (op_age >= ack_wait) begin
        mac_ack    = 1'b1;
        mac_result = r2f(f2r(op_a) * f2r(op_b) + f2r(op_c));
        a_log.push_back(op_a);
        n_ops++;
        op_age = 0;
      end else begin
        mac_ack = 1'b0;
        op_age++;
      end
    end else begin
      mac_ack = 1'b0;
      op_age  = 0;
    end
  end

  task automatic set_ones(logic [31:0] zz);
    z = zz;
    for (int i = 0; i <= 10; i++) coeff[i] = 32'h3F80_0000;
  endtask

  task automatic accept(logic [31:0] exp_y, logic exp_err);
    int t = 0;
    @(negedge clk);
    in_valid = 1'b1;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("accept_ready", 32'(in_ready), 32'd1);
    sb_y.push_back(exp_y);
    sb_e.push_back(exp_err);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic collect(int exp_lat, bit scramble, int hold);
    int          lat = 1;
    logic [31:0] ey;
    logic        ee;
    while (!y_valid && lat < 3000) begin
      if (scramble) begin
        z = $urandom;
        for (int i = 0; i <= 10; i++) coeff[i] = $urandom;
      end
      @(negedge clk);
      lat++;
    end
    if (sb_y.size() > 0) begin
      ey = sb_y.pop_front();
      ee = sb_e.pop_front();
    end else begin
      ey = 'x;
      ee = 1'bx;
    end
    check("y_valid", 32'(y_valid), 32'd1);
    check("latency", 32'(lat), 32'(exp_lat));
    check("y", y, ey);
    check("err", 32'(err), 32'(ee));
    check("mac_req_done", 32'(mac_req), 32'd0);
    check("in_ready_done", 32'(in_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      in_valid = ~in_valid;
      z = $urandom;
      @(negedge clk);
      check("hold_y", y, ey);
      check("hold_y_valid", 32'(y_valid), 32'd1);
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    y_ready  = 1'b1;
    @(negedge clk);
    y_ready  = 1'b0;
    check("idle_in_ready", 32'(in_ready), 32'd1);
    check("idle_y_valid", 32'(y_valid), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i <= 10; i++) coeff[i] = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_y_valid", 32'(y_valid), 32'd0);
    check("rst_mac_req", 32'(mac_req), 32'd0);
    check("rst_mac_a", mac_a, 32'h0);
    check("rst_mac_b", mac_b, 32'h0);
    check("rst_mac_c", mac_c, 32'h0);
    check("rst_y", y, 32'h0);
    check("rst_err", 32'(err), 32'd0);
    GlobalReset = 1'b1;

    // z=1, all ones, zero-wait MAC -> 11.0 at cycle 11
    ack_wait = 0;
    set_ones(32'h3F80_0000);
    n_ops = 0;
    accept(32'h4130_0000, 1'b0);
    collect(11, 1'b0, 0);
    check("ops_zero_wait", 32'(n_ops), 32'd10);

    // z=2, only c10=1, ack on third req cycle -> 1024.0 at cycle 31
    ack_wait = 2;
    z = 32'h4000_0000;
    for (int i = 0; i < 10; i++) coeff[i] = 32'h0;
    coeff[10] = 32'h3F80_0000;
    a_log.delete();
    accept(32'h4480_0000, 1'b0);
    collect(31, 1'b0, 0);
    check("a_log_size", 32'(a_log.size()), 32'd10);
    for (int i = 0; i < 10 && i < a_log.size(); i++)
      check("a_seq", a_log[i], 32'h3F80_0000 + (32'(i) << 23));

    // inputs churn every cycle while busy
    ack_wait = 0;
    set_ones(32'h3F80_0000);
    accept(32'h4130_0000, 1'b0);
    collect(11, 1'b1, 0);

    // hold result 5 cycles with in_valid pulsing, then next sample c_i=i+1, z=2 -> 20481.0
    set_ones(32'h3F80_0000);
    accept(32'h4130_0000, 1'b0);
    collect(11, 1'b0, 5);
    z = 32'h4000_0000;
    for (int i = 0; i <= 10; i++) coeff[i] = r2f(real'(i + 1));
    accept(32'h46A0_0200, 1'b0);
    collect(11, 1'b0, 0);

    // z=0.5, all ones, two cycles per op -> 2-2^-10 at cycle 21
    ack_wait = 1;
    set_ones(32'h3F00_0000);
    accept(32'h3FFF_E000, 1'b0);
    collect(21, 1'b0, 0);

    // no ack ever: 16 busy cycles then NaN with err
    ack_wait = 100000;
    set_ones(32'h3F80_0000);
    req_cycles = 0;
    accept(32'h7FC0_0000, 1'b1);
    collect(17, 1'b0, 0);
    check("timeout_req_cycles", 32'(req_cycles), 32'(TIMEOUT));
    ack_wait = 0;
    accept(32'h4130_0000, 1'b0);
    collect(11, 1'b0, 0);

    // asynchronous reset in the middle of k=5
    accept(32'h4130_0000, 1'b0);
    repeat (4) @(negedge clk);
    #2;
    GlobalReset = 1'b0;
    #1;
    check("mid_rst_mac_req", 32'(mac_req), 32'd0);
    check("mid_rst_mac_a", mac_a, 32'h0);
    check("mid_rst_mac_b", mac_b, 32'h0);
    check("mid_rst_mac_c", mac_c, 32'h0);
    check("mid_rst_y_valid", 32'(y_valid), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_y", y, 32'h0);
    check("mid_rst_err", 32'(err), 32'd0);
    void'(sb_y.pop_back());
    void'(sb_e.pop_back());
    @(negedge clk);
    GlobalReset = 1'b1;
    inject_ack  = 1'b1;
    repeat (3) @(negedge clk);
    check("stray_ack_in_ready", 32'(in_ready), 32'd1);
    check("stray_ack_mac_req", 32'(mac_req), 32'd0);
    check("stray_ack_y_valid", 32'(y_valid), 32'd0);
    check("stray_ack_mac_a", mac_a, 32'h0);
    set_ones(32'h3F80_0000);
    accept(32'h4130_0000, 1'b0);
    collect(11, 1'b0, 0);
    check("sb_drained", 32'(sb_y.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/horner_sequencer.md
Name: horner_sequencer

Overview:
- Evaluates the degree-DEGREE section polynomial y = c0 + z·(c1 + z·(… + z·c10)) by Horner iteration.
- Sits directly downstream of the section comparator:
  - coeff0..coeff10 come from the comparator's registered outputs.
  - z is the normalized sample, (x + negated mean) × reciprocal std.
- Owns no FP arithmetic. Each step is issued to the shared FP multiply-add unit (result = a·b + c) over a req/ack handshake.
- Snapshots z and coefficients on accept, so the comparator may move on to the next sample.

Parameters:
- DEGREE, 10, polynomial degree. Legal range 1..10. Coefficients above DEGREE are ignored.
- TIMEOUT, 255, maximum cycles to wait for mac_ack on one operation before aborting.
- CW, 8, width of the timeout counter. Must satisfy 2^CW > TIMEOUT.

Ports:
- clk  input  1  system clock, rising edge.
- GlobalReset  input  1  asynchronous, active-low reset.
- in_valid  input  1  z/coefficients valid.
- in_ready  output  1  block can accept; high only in IDLE.
- z  input  32  IEEE-754 single, normalized sample.
- coeff0..coeff10  input  32 each  IEEE-754 single section coefficients, c0..c10.
- mac_req  output  1  operation request to the FP multiply-add unit.
- mac_a  output  32  multiplicand (accumulator).
- mac_b  output  32  multiplier (z snapshot).
- mac_c  output  32  addend (coefficient).
- mac_ack  input  1  result valid this cycle.
- mac_result  input  32  a·b + c.
- y_valid  output  1  result available.
- y_ready  input  1  consumer takes result.
- y  output  32  polynomial result.
- err  output  1  result produced by timeout abort; qualified by y_valid.

Behaviour:
- Reset: clock and reset are as already decided — one clock; reset asynchronous and active-low. While GlobalReset=0, regardless of clk:
  - state=IDLE; y=0, y_valid=0, err=0.
  - mac_req=0; mac_a/mac_b/mac_c=0.
  - k=0; timeout counter=0; snapshots=0.
  - in_ready=1 (IDLE).
- Reset mid-operation: aborts immediately. No result is produced. An ack arriving after release is ignored, because mac_ack is only sampled in BUSY.
- States: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready:
    - latch z and c0..c10;
    - acc<=c[DEGREE]; k<=DEGREE-1; tcnt<=0; err<=0;
    - go to BUSY.
- BUSY:
  - mac_req=1, mac_a=acc, mac_b=z_r, mac_c=c_r[k]. All are registered and stable while awaiting ack.
  - On mac_ack:
    - acc<=mac_result; tcnt<=0.
    - If k==0, go to DONE (y<=mac_result).
    - Else k<=k-1, and the next operands appear the following cycle with mac_req held high (back-to-back allowed).
  - Without ack: tcnt<=tcnt+1.
  - If tcnt reaches TIMEOUT-1 with no ack: go to DONE with y=32'h7FC00000 (quiet NaN), err=1, mac_req=0.
- DONE:
  - y_valid=1; y and err held stable; in_ready=0; mac_req=0.
  - On y_ready, go to IDLE next cycle (y_valid=0, in_ready=1).
- Outside IDLE:
  - in_valid is ignored; no snapshot update.
  - Coefficient/z input changes have no effect.
- mac_ack outside BUSY is ignored.
- Latency, accept cycle = 0:
  - With a zero-wait MAC (ack in the first req cycle), y_valid rises at cycle DEGREE+1.
  - In general, latency = 1 + Σ(cycles per op).
- Exactly DEGREE MAC operations per sample, with k stepping DEGREE-1 down to 0.

Test Plan:
- Zero-wait MAC model; z=0x3F800000 (1.0); all coeffs 1.0 -> y=0x41300000 (11.0), y_valid at cycle 11 after accept, 10 req/ack pairs, err=0.
- MAC acks on 3rd req cycle; z=0x40000000 (2.0); coeff10=1.0, others 0 -> y=0x44800000 (1024.0), y_valid at cycle 31. mac_a sequence 1,2,4,…,512, with each operand stable for 3 cycles.
- Change all coeff inputs and z every cycle during BUSY -> result identical to the 1.0/11.0 case.
- Hold y_ready=0 for 5 cycles in DONE while pulsing in_valid:
  - y held and in_ready=0; no new accept.
  - y_ready=1 -> IDLE next cycle, in_ready=1, next sample accepted.
- TIMEOUT=16, mac_ack never asserted -> 16 BUSY cycles, then y=0x7FC00000, err=1, mac_req=0. The next transaction has err=0.
- Assert GlobalReset low mid-BUSY (k=5), asynchronously between edges:
  - all outputs take reset values immediately;
  - an ack pulse after release is ignored;
  - the following transaction yields correct 11.0.
